// File: rtl/phase3_motion_update.sv
// phase3_motion_update
// ---------------------------------------------------------------------------
// Motion-update sweep over a double-buffered particle store. For each slot
// 0..N_PART-1 the block issues one read from the latched bank, and on the
// following cycle writes the integrated particle state to the opposite bank:
//     v' = vel + (frc >>> DT_SHIFT)
//     p' = pos + (v'  >>> DT_SHIFT)
// Empty slots (rd_occ = 0) are copied through unchanged.
//
// Configuration macro:
//     PHASE3_SAT_EN  defined   -> v' and p' saturate to the signed DATA_W range
//                    undefined -> v' and p' wrap (two's complement)
//
// Timing: READ and WRITE alternate one cycle each. A full sweep therefore
// takes 2*N_PART cycles from entering READ to entering DONE. Read data
// arrives one cycle after rd_en, which is the WRITE cycle, so the write data
// path is combinational from the read data while all control outputs come
// straight from flops.
// ---------------------------------------------------------------------------
module phase3_motion_update #(
    parameter int N_PART   = 64,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 16,
    parameter int DT_SHIFT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              phase3_ready,
    input  logic              double_buffer,
    output logic              phase3_done,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_pos,
    input  logic [DATA_W-1:0] rd_vel,
    input  logic [DATA_W-1:0] rd_frc,
    input  logic              rd_occ,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_pos,
    output logic [DATA_W-1:0] wr_vel,
    output logic              wr_occ
);

    // Last slot of the sweep; the address never advances past it.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PART - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Signed add of two DATA_W values with the configured overflow behaviour.
    // Overflow only happens when both operands share a sign and the sum's
    // sign differs; in that case the result clamps toward the operand sign.
    // -----------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] add_fit(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] sum;
        sum = a + b;
`ifdef PHASE3_SAT_EN
        if ((a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1])) begin
            if (a[DATA_W-1]) begin
                add_fit = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                add_fit = {1'b0, {(DATA_W-1){1'b1}}};
            end
        end else begin
            add_fit = sum;
        end
`else
        add_fit = sum;
`endif
    endfunction

    // State and sweep registers
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_bank;
    logic              r_rd_en;
    logic              r_wr_en;
    logic              r_done;

    // Next-state values
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_bank_nxt;

    // Datapath intermediates
    logic [DATA_W-1:0] w_frc_sh;
    logic [DATA_W-1:0] w_vel_new;
    logic [DATA_W-1:0] w_vel_sh;
    logic [DATA_W-1:0] w_pos_new;
    logic [DATA_W-1:0] w_wr_pos;
    logic [DATA_W-1:0] w_wr_vel;
    logic              w_wr_occ;

    // Sweep sequencing: bank/addr latch in IDLE, READ/WRITE alternation, DONE handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_bank_nxt  = r_bank;
        case (r_state)
            ST_IDLE: begin
                if (phase3_ready) begin
                    w_state_nxt = ST_READ;
                    w_bank_nxt  = double_buffer;
                    w_addr_nxt  = {ADDR_W{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                if (r_addr == LAST_ADDR) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_READ;
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                end
            end
            ST_DONE: begin
                if (phase3_ready) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_addr_nxt  = {ADDR_W{1'b0}};
                w_bank_nxt  = 1'b0;
            end
        endcase
    end

    // State, address and latched-bank registers; reset aborts any sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= {ADDR_W{1'b0}};
            r_bank  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_bank  <= w_bank_nxt;
        end
    end

    // Registered control strobes decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_rd_en <= (w_state_nxt == ST_READ);
            r_wr_en <= (w_state_nxt == ST_WRITE);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Integration: velocity first, then position from the new velocity.
    always_comb begin
        w_frc_sh  = $signed(rd_frc) >>> DT_SHIFT;
        w_vel_new = add_fit(rd_vel, w_frc_sh);
        w_vel_sh  = $signed(w_vel_new) >>> DT_SHIFT;
        w_pos_new = add_fit(rd_pos, w_vel_sh);
    end

    // Write data select: integrated for occupied slots, copy for empty ones, zero when idle.
    always_comb begin
        w_wr_pos = {DATA_W{1'b0}};
        w_wr_vel = {DATA_W{1'b0}};
        w_wr_occ = 1'b0;
        if (!r_wr_en) begin
            w_wr_pos = {DATA_W{1'b0}};
            w_wr_vel = {DATA_W{1'b0}};
            w_wr_occ = 1'b0;
        end else if (rd_occ) begin
            w_wr_pos = w_pos_new;
            w_wr_vel = w_vel_new;
            w_wr_occ = 1'b1;
        end else begin
            w_wr_pos = rd_pos;
            w_wr_vel = rd_vel;
            w_wr_occ = 1'b0;
        end
    end

    // Output mapping; bank/address are forced to zero whenever their strobe is low.
    assign phase3_done = r_done;
    assign rd_en       = r_rd_en;
    assign rd_bank     = r_rd_en & r_bank;
    assign rd_addr     = r_rd_en ? r_addr : {ADDR_W{1'b0}};
    assign wr_en       = r_wr_en;
    assign wr_bank     = r_wr_en & ~r_bank;
    assign wr_addr     = r_wr_en ? r_addr : {ADDR_W{1'b0}};
    assign wr_pos      = w_wr_pos;
    assign wr_vel      = w_wr_vel;
    assign wr_occ      = w_wr_occ;

endmodule

// File: tb/tb_phase3_motion_update.sv
// Bench for phase3_motion_update with N_PART=4. A small particle memory
// answers reads one cycle late; an expected-write list is built from the
// integration equations when each sweep starts and a per-cycle monitor
// checks every read and write against it.
module tb_phase3_motion_update;

    localparam int NP = 4;
    localparam int AW = 2;
    localparam int DW = 16;
    localparam int SH = 2;
`ifdef PHASE3_SAT_EN
    localparam int EXP_P2 = 32767;
`else
    localparam int EXP_P2 = -32669;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          ready;
    logic          db;
    logic          done;
    logic          rd_en, rd_bank, rd_occ;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_pos, rd_vel, rd_frc;
    logic          wr_en, wr_bank, wr_occ;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_pos, wr_vel;

    phase3_motion_update #(.N_PART(NP), .ADDR_W(AW), .DATA_W(DW), .DT_SHIFT(SH)) dut (
        .clk(clk), .reset(reset), .phase3_ready(ready), .double_buffer(db),
        .phase3_done(done),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .rd_pos(rd_pos), .rd_vel(rd_vel), .rd_frc(rd_frc), .rd_occ(rd_occ),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .wr_pos(wr_pos), .wr_vel(wr_vel), .wr_occ(wr_occ)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Particle memory: [bank][addr]
    int m_pos[2][NP];
    int m_vel[2][NP];
    int m_frc[2][NP];
    bit m_occ[2][NP];

    // Read port: data one cycle after rd_en, garbage otherwise
    always @(posedge clk) begin
        if (rd_en === 1'b1) begin
            rd_pos <= DW'(m_pos[rd_bank][rd_addr]);
            rd_vel <= DW'(m_vel[rd_bank][rd_addr]);
            rd_frc <= DW'(m_frc[rd_bank][rd_addr]);
            rd_occ <= m_occ[rd_bank][rd_addr];
        end else begin
            rd_pos <= DW'($urandom);
            rd_vel <= DW'($urandom);
            rd_frc <= DW'($urandom);
            rd_occ <= 1'($urandom);
        end
    end

    // Behavioural model: signed 16-bit arithmetic with wrap or clamp
    function automatic int fit16(input int x);
`ifdef PHASE3_SAT_EN
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
`else
        int y;
        y = x & 32'h0000FFFF;
        if (y >= 32768) y = y - 65536;
        return y;
`endif
    endfunction

    function automatic void model(input int p, input int v, input int f, input bit occ,
                                  output int np, output int nv);
        if (occ) begin
            nv = fit16(v + (f >>> SH));
            np = fit16(p + (nv >>> SH));
        end else begin
            nv = v;
            np = p;
        end
    endfunction

    typedef struct {
        int addr;
        bit bank;
        int pos;
        int vel;
        bit occ;
    } wr_t;

    wr_t exp_q[$];
    int  exp_rd_addr;
    bit  exp_bank;
    bit  mon_on = 1'b0;
    int  n_wr;
    int  cap_pos[NP];
    int  cap_vel[NP];
    int  cap_occ[NP];

    task automatic start_sweep(input bit bank);
        int np, nv;
        wr_t e;
        exp_q.delete();
        exp_rd_addr = 0;
        exp_bank    = bank;
        n_wr        = 0;
        for (int a = 0; a < NP; a++) begin
            model(m_pos[bank][a], m_vel[bank][a], m_frc[bank][a], m_occ[bank][a], np, nv);
            e.addr = a;
            e.bank = ~bank;
            e.pos  = np;
            e.vel  = nv;
            e.occ  = m_occ[bank][a];
            exp_q.push_back(e);
        end
    endtask

    // Per-cycle monitor of the read and write ports
    always @(negedge clk) begin
        wr_t e;
        if (mon_on) begin
            chk("en_exclusive", int'(rd_en & wr_en), 0);
            if (rd_en) begin
                chk("rd_bank", int'(rd_bank), int'(exp_bank));
                chk("rd_addr", int'(rd_addr), exp_rd_addr);
                exp_rd_addr++;
            end
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", int'(wr_addr), e.addr);
                    chk("wr_bank", int'(wr_bank), int'(e.bank));
                    chk("wr_pos", int'($signed(wr_pos)), e.pos);
                    chk("wr_vel", int'($signed(wr_vel)), e.vel);
                    chk("wr_occ", int'(wr_occ), int'(e.occ));
                    cap_pos[e.addr] = int'($signed(wr_pos));
                    cap_vel[e.addr] = int'($signed(wr_vel));
                    cap_occ[e.addr] = int'(wr_occ);
                    n_wr++;
                end
            end
        end
    end

    task automatic wait_first_read(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rd_en && k < 10);
        if (!rd_en) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string name, output int cycles);
        cycles = 0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        if (!done) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int np, nv, t, k;
        reset = 1'b1; ready = 1'b0; db = 1'b0;

        // Memory contents
        m_pos[0] = '{100, -5, 32767, -20};
        m_vel[0] = '{8, 7, 400, -3};
        m_frc[0] = '{16, 99, 0, -9};
        m_occ[0] = '{1'b1, 1'b0, 1'b1, 1'b1};
        m_pos[1] = '{10, 0, -32768, 7};
        m_vel[1] = '{-40, 0, -400, 1};
        m_frc[1] = '{-100, 3, 0, 1};
        m_occ[1] = '{1'b1, 1'b1, 1'b1, 1'b0};

        // Pin the model with hand-computed values
        model(100, 8, 16, 1'b1, np, nv);
        chk("model_p0", np, 103);
        chk("model_v0", nv, 12);
        model(-20, -3, -9, 1'b1, np, nv);
        chk("model_p3", np, -22);
        chk("model_v3", nv, -6);
        model(32767, 400, 0, 1'b1, np, nv);
        chk("model_p2", np, EXP_P2);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_wr_pos", int'(wr_pos), 0);
        chk("rst_wr_occ", int'(wr_occ), 0);
        reset = 1'b0;
        mon_on = 1'b1;

        // Sweep 1: bank 0, ready held through DONE
        repeat (2) @(negedge clk);
        start_sweep(1'b0);
        ready = 1'b1;
        wait_first_read("s1_read");
        wait_done("s1_done", t);
        chk("done_latency", t, 2 * NP);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("done_held", int'(done), 1);
            chk("done_rd_en", int'(rd_en), 0);
        end
        ready = 1'b0;
        @(negedge clk);
        chk("done_release", int'(done), 0);
        repeat (2) begin
            @(negedge clk);
            chk("idle_rd_en", int'(rd_en), 0);
        end
        chk("s1_writes", n_wr, NP);
        chk("lit_p0", cap_pos[0], 103);
        chk("lit_v0", cap_vel[0], 12);
        chk("lit_o0", cap_occ[0], 1);
        chk("lit_p1", cap_pos[1], -5);
        chk("lit_v1", cap_vel[1], 7);
        chk("lit_o1", cap_occ[1], 0);
        chk("lit_p2", cap_pos[2], EXP_P2);

        // Sweep 2: bank 1, double_buffer toggled and ready dropped mid-sweep
        db = 1'b1;
        start_sweep(1'b1);
        ready = 1'b1;
        @(negedge clk);
        db = 1'b0;
        repeat (2) @(negedge clk);
        ready = 1'b0;
        db = 1'b1;
        @(negedge clk);
        db = 1'b0;
        wait_done("s2_done", t);
        @(negedge clk);
        chk("s2_done_release", int'(done), 0);
        chk("s2_writes", n_wr, NP);

        // Sweep 3: reset during the write of slot 2
        repeat (2) @(negedge clk);
        start_sweep(1'b0);
        ready = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(wr_en && wr_addr == AW'(2)) && k < 40);
        if (!(wr_en && wr_addr == AW'(2))) chk("s3_wr2_timeout", 0, 1);
        reset = 1'b1;
        ready = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_abort_wr_en", int'(wr_en), 0);
            chk("rst_abort_rd_en", int'(rd_en), 0);
        end
        chk("s3_writes_before_abort", n_wr, 3);
        reset = 1'b0;
        @(negedge clk);
        start_sweep(1'b0);
        ready = 1'b1;
        wait_first_read("s4_read");
        chk("restart_addr", int'(rd_addr), 0);
        wait_done("s4_done", t);
        ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("s4_writes", n_wr, NP);
        chk("s4_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
